cp0_reg: RTL and testbench

// - Coprocessor-0 register file. Consumes MEM-stage exception info and mtc0 writes; produces
//   EPC (to ctrl as cp0_epc_i), STATUS/CAUSE (to MEM exception resolution) and timer_int_o
//   (looped back into int_i[5]). Sits beside MEM/WB, directly upstream of ctrl.

---
 rtl/cp0_reg_pkg.sv | 30 +++
 rtl/cp0_reg_timer.sv | 39 +++
 rtl/cp0_reg.sv | 113 +++++++++++
 tb/tb_cp0_reg.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// CP0 register file shared constants.
// Register numbers, exception types and ExcCodes.
package cp0_reg_pkg;

  localparam logic [31:0] PRID_VAL   = 32'h004c0102;
  localparam logic [31:0] CONFIG_RST = 32'h00008000;
  localparam logic [31:0] STATUS_RST = 32'h10000000;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;
  localparam logic [4:0] CP0_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [4:0] ECODE_INT     = 5'd0;
  localparam logic [4:0] ECODE_SYSCALL = 5'd8;
  localparam logic [4:0] ECODE_INVALID = 5'd10;
  localparam logic [4:0] ECODE_OV      = 5'd12;
  localparam logic [4:0] ECODE_TRAP    = 5'd13;

endpackage

// File: rtl/cp0_reg_timer.sv
// Count/Compare pair and timer interrupt.
// Interrupt is sticky until Compare is rewritten.
module cp0_reg_timer
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic wr_count;
  logic wr_compare;

  assign wr_count   = we && (waddr == CP0_COUNT);
  assign wr_compare = we && (waddr == CP0_COMPARE);

  // free-running count, loadable compare, sticky match flag
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      count <= wr_count ? data : count + 32'd1;
      if ((compare != '0) && (count == compare))
        timer_int <= 1'b1;
      if (wr_compare) begin
        compare   <= data;
        timer_int <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file.
// Exceptions override mtc0 on the same edge.
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        exc_take;
  logic [4:0]  exc_code;

  cp0_reg_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .we        (we_i),
    .waddr     (waddr_i),
    .data      (data_i),
    .count     (count_o),
    .compare   (compare_o),
    .timer_int (timer_int_o)
  );

  // map exception type to the ExcCode it records
  always_comb begin
    exc_take = 1'b1;
    exc_code = ECODE_INT;
    case (excepttype_i)
      EXC_INT:     exc_code = ECODE_INT;
      EXC_SYSCALL: exc_code = ECODE_SYSCALL;
      EXC_INVALID: exc_code = ECODE_INVALID;
      EXC_OV:      exc_code = ECODE_OV;
      EXC_TRAP:    exc_code = ECODE_TRAP;
      default:     exc_take = 1'b0;
    endcase
  end

  // status/cause/epc: mtc0 first, exception last so it wins
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RST;
      cause  <= '0;
      epc    <= '0;
    end else begin
      cause[15:10] <= int_i;
      if (we_i) begin
        case (waddr_i)
          CP0_STATUS: status <= data_i;
          CP0_EPC:    epc    <= data_i;
          CP0_CAUSE: begin
            cause[9:8]   <= data_i[9:8];
            cause[23:22] <= data_i[23:22];
          end
          default: ;
        endcase
      end
      if (exc_take) begin
        if (!status[1]) begin
          epc <= is_in_delayslot_i ?
                 current_inst_addr_i - 32'd4 :
                 current_inst_addr_i;
          cause[31] <= is_in_delayslot_i;
        end
        status[1]  <= 1'b1;
        cause[6:2] <= exc_code;
      end else if (excepttype_i == EXC_ERET) begin
        status[1] <= 1'b0;
      end
    end
  end

  // combinational mfc0 read, unmapped reads as zero
  always_comb begin
    data_o = '0;
    case (raddr_i)
      CP0_COUNT:   data_o = count_o;
      CP0_COMPARE: data_o = compare_o;
      CP0_STATUS:  data_o = status;
      CP0_CAUSE:   data_o = cause;
      CP0_EPC:     data_o = epc;
      CP0_PRID:    data_o = PRID_VAL;
      CP0_CONFIG:  data_o = CONFIG_RST;
      default:     data_o = '0;
    endcase
  end

  assign status_o = status;
  assign cause_o  = cause;
  assign epc_o    = epc;
  assign config_o = CONFIG_RST;
  assign prid_o   = PRID_VAL;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg.
// Hand-computed expectations, immediate assertions.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  int n_chk = 0;
  int n_fail = 0;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .raddr_i             (raddr_i),
    .data_i              (data_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1;
    waddr_i = a;
    data_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic exc(input logic [31:0] t,
                     input logic [31:0] pc,
                     input logic ds);
    excepttype_i = t;
    current_inst_addr_i = pc;
    is_in_delayslot_i = ds;
    tick();
    excepttype_i = '0;
    is_in_delayslot_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    we_i = 1'b0;
    waddr_i = '0;
    raddr_i = '0;
    data_i = '0;
    int_i = '0;
    excepttype_i = '0;
    current_inst_addr_i = '0;
    is_in_delayslot_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_status", status_o, 32'h10000000);
    chk("rst_config", config_o, 32'h00008000);
    chk("rst_prid", prid_o, 32'h004c0102);
    chk("rst_count", count_o, 32'h0);
    chk("rst_compare", compare_o, 32'h0);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_timer", {31'b0, timer_int_o}, 32'h0);
    raddr_i = 5'd15;
    #1;
    chk("rd_prid", data_o, 32'h004c0102);
    raddr_i = 5'd3;
    #1;
    chk("rd_unmapped", data_o, 32'h0);

    mtc0(5'd9, 32'hFFFFFFFE);
    chk("cnt_load", count_o, 32'hFFFFFFFE);
    tick();
    chk("cnt_max", count_o, 32'hFFFFFFFF);
    tick();
    raddr_i = 5'd9;
    #1;
    chk("cnt_wrap", data_o, 32'h0);

    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd10);
    chk("tmr_cnt10", count_o, 32'd10);
    chk("tmr_cmp", compare_o, 32'd20);
    repeat (10) tick();
    chk("tmr_cnt20", count_o, 32'd20);
    chk("tmr_low_at_eq", {31'b0, timer_int_o}, 32'h0);
    tick();
    chk("tmr_rise", {31'b0, timer_int_o}, 32'h1);
    tick();
    chk("tmr_sticky", {31'b0, timer_int_o}, 32'h1);
    mtc0(5'd11, 32'd0);
    chk("tmr_clear", {31'b0, timer_int_o}, 32'h0);

    exc(32'h08, 32'h100, 1'b0);
    chk("sys_epc", epc_o, 32'h100);
    chk("sys_code", {27'b0, cause_o[6:2]}, 32'd8);
    chk("sys_bd", {31'b0, cause_o[31]}, 32'h0);
    chk("sys_status", status_o, 32'h10000002);
    exc(32'h0e, 32'h0, 1'b0);
    chk("eret1", status_o, 32'h10000000);

    exc(32'h0c, 32'h204, 1'b1);
    chk("ov_epc", epc_o, 32'h200);
    chk("ov_bd", {31'b0, cause_o[31]}, 32'h1);
    chk("ov_code", {27'b0, cause_o[6:2]}, 32'd12);
    chk("ov_exl", {31'b0, status_o[1]}, 32'h1);
    exc(32'h08, 32'h400, 1'b0);
    chk("exl_epc_hold", epc_o, 32'h200);
    chk("exl_bd_hold", {31'b0, cause_o[31]}, 32'h1);
    chk("exl_code", {27'b0, cause_o[6:2]}, 32'd8);
    exc(32'h0e, 32'h0, 1'b0);
    chk("eret2", {31'b0, status_o[1]}, 32'h0);

    we_i = 1'b1;
    waddr_i = 5'd14;
    data_i = 32'hDEAD;
    int_i = 6'b000001;
    exc(32'h0d, 32'h300, 1'b0);
    we_i = 1'b0;
    chk("trap_epc", epc_o, 32'h300);
    chk("trap_ip2", {31'b0, cause_o[10]}, 32'h1);
    chk("trap_code", {27'b0, cause_o[6:2]}, 32'd13);
    exc(32'h0e, 32'h0, 1'b0);

    int_i = 6'b0;
    mtc0(5'd13, 32'hFFFFFFFF);
    chk("cause_mask", cause_o, 32'h00C00334);
    mtc0(5'd12, 32'h0000FF01);
    chk("status_wr", status_o, 32'h0000FF01);
    exc(32'h05, 32'h500, 1'b1);
    chk("unk_status", status_o, 32'h0000FF01);
    chk("unk_epc", epc_o, 32'h300);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_status", status_o, 32'h10000000);
    chk("mid_rst_cause", cause_o, 32'h0);
    chk("mid_rst_count", count_o, 32'h0);
    chk("mid_rst_epc", epc_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
